// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter that time-shares one add/sub datapath between the ALU
// issue path (id 0) and the branch/AGU path (id 1), with a one-entry output register.
module addsub_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_rs1,
  input  logic [WIDTH-1:0] req0_rs2,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_rs1,
  input  logic [WIDTH-1:0] req1_rs2,
  input  logic             req1_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_id
);

  logic             last_grant;
  logic             slot_free;
  logic             grant_ok;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             sub_sel;
  logic             ovf;

  // rst_n gates the grant so neither requester sees ready while held in reset.
  always_comb begin
    slot_free = !out_valid || out_ready;
    grant_ok  = rst_n && en && slot_free;
    gnt0      = grant_ok && req0_valid && (!req1_valid || last_grant);
    gnt1      = grant_ok && req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Subtraction reuses the adder as A + ~B + 1; overflow then has one form.
  always_comb begin
    op_a    = req0_rs1;
    op_b    = req0_rs2;
    sub_sel = req0_sub;
    if (gnt1) begin
      op_a    = req1_rs1;
      op_b    = req1_rs2;
      sub_sel = req1_sub;
    end
    b_eff = sub_sel ? ~op_b : op_b;
    sum   = op_a + b_eff + {{(WIDTH-1){1'b0}}, sub_sel};
    ovf   = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= 1'b1;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_id       <= 1'b0;
    end else if (gnt0 || gnt1) begin
      last_grant   <= gnt1;
      out_valid    <= 1'b1;
      out_result   <= sum;
      out_overflow <= ovf;
      out_id       <= gnt1;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Scenario bench for addsub_share_arbiter: expected results are queued at
// issue time from a signed-arithmetic model and compared as the output drains.
module tb_addsub_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        r0v, r0s, r1v, r1s;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_ready, out_overflow, out_id;
  logic [31:0] out_result;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        id;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  addsub_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_rs1(r0a), .req0_rs2(r0b), .req0_sub(r0s),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_rs1(r1a), .req1_rs2(r1b), .req1_sub(r1s),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_id(out_id)
  );

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic id);
    exp_t   m;
    longint sa, sbv, r, max_pos, min_neg;
    sa      = longint'($signed(a));
    sbv     = longint'($signed(b));
    r       = s ? sa - sbv : sa + sbv;
    max_pos = 2147483647;
    min_neg = -max_pos - 1;
    m.res   = r[31:0];
    m.ovf   = (r > max_pos) || (r < min_neg);
    m.id    = id;
    return m;
  endfunction

  // Called at the negedge: records whatever transfer the DUT accepts this cycle.
  task automatic push_grants();
    if (r0v && req0_ready) sb.push_back(model(r0a, r0b, r0s, 1'b0));
    if (r1v && req1_ready) sb.push_back(model(r1a, r1b, r1s, 1'b1));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got result=%h id=%0d, required no pending result",
                 out_result, out_id);
      end else begin
        e = sb.pop_front();
        if (out_result !== e.res || out_overflow !== e.ovf || out_id !== e.id) begin
          miscompares++;
          $display("FAIL result_check: got res=%h ovf=%0b id=%0b, required res=%h ovf=%0b id=%0b",
                   out_result, out_overflow, out_id, e.res, e.ovf, e.id);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b1;
    r0v = 1'b1; r0a = 32'd1; r0b = 32'd1; r0s = 1'b0;
    r1v = 1'b1; r1a = 32'd2; r1b = 32'd2; r1s = 1'b0;
    #3;
    vectors++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_overflow !== 1'b0 || out_id !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%0b res=%h ovf=%0b id=%0b, required all zero",
               out_valid, out_result, out_overflow, out_id);
    end
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got r0=%0b r1=%0b, required 0 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    r0v = 1'b1; r0a = 32'd5; r0b = 32'd3; r0s = 1'b0;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_grant: got r0=%0b r1=%0b, required 1 0", req0_ready, req1_ready);
    end
    push_grants();
    @(posedge clk); #1;
    r0v = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_id !== 1'b0 || out_result !== 32'd8) begin
      miscompares++;
      $display("FAIL single_latency: got v=%0b id=%0b res=%h, required 1 0 00000008",
               out_valid, out_id, out_result);
    end
  endtask

  task automatic test_arith();
    logic [31:0] ta [3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    logic        ts [3] = '{1'b1, 1'b0, 1'b0};
    logic        tid[3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      if (tid[i]) begin r1v = 1'b1; r1a = ta[i]; r1b = tb[i]; r1s = ts[i]; end
      else        begin r0v = 1'b1; r0a = ta[i]; r0b = tb[i]; r0s = ts[i]; end
      @(negedge clk);
      vectors++;
      if (req0_ready !== !tid[i] || req1_ready !== tid[i]) begin
        miscompares++;
        $display("FAIL arith_grant[%0d]: got r0=%0b r1=%0b, required id %0d", i,
                 req0_ready, req1_ready, tid[i]);
      end
      push_grants();
      @(posedge clk); #1;
      r0v = 1'b0; r1v = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    r0v = 1'b1; r0a = 32'd100; r0b = 32'd7; r0s = 1'b1;
    r1v = 1'b1; r1a = 32'h1000; r1b = 32'h0234; r1s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got r0=%0b r1=%0b, required id %0d", i,
                 req0_ready, req1_ready, i % 2);
      end
      if (i > 0) begin
        vectors++;
        if (out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL rr_throughput[%0d]: got out_valid=%0b, required 1", i, out_valid);
        end
      end
      push_grants();
      @(posedge clk); #1;
      if (i % 2 == 0) begin r0a = $urandom; r0b = $urandom; r0s = 1'($urandom_range(0, 1)); end
      else            begin r1a = $urandom; r1b = $urandom; r1s = 1'($urandom_range(0, 1)); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready[%0d]: got r0=%0b r1=%0b, required 0 0", i, req0_ready, req1_ready);
      end
      vectors++;
      if (sb.size() != 1 || out_valid !== 1'b1 || out_result !== sb[0].res || out_id !== sb[0].id) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%0b res=%h id=%0b pending=%0d, required held entry",
                 i, out_valid, out_result, out_id, sb.size());
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain_grant: got r0=%0b r1=%0b, required 1 0", req0_ready, req1_ready);
    end
    push_grants();
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_id !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_reload: got v=%0b id=%0b, required 1 0", out_valid, out_id);
    end
  endtask

  task automatic test_enable();
    en = 1'b0; r1v = 1'b0;
    r0v = 1'b1; r0a = 32'd40; r0b = 32'd50; r0s = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL en_low_grant: got r0=%0b, required 0", req0_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL en_low_drain: got v=%0b r0=%0b, required 0 0", out_valid, req0_ready);
    end
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL en_high_grant: got r0=%0b, required 1", req0_ready);
    end
    push_grants();
    @(posedge clk); #1;
    r0v = 1'b0;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    r0v = 1'b1; r0a = 32'd9; r0b = 32'd9; r0s = 1'b0;
    @(negedge clk);
    push_grants();
    @(posedge clk); #1;
    r0v = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got out_valid=%0b, required 0", out_valid);
    end
    sb.delete();
    r0v = 1'b1; r0a = 32'h0000_0010; r0b = 32'h0000_0020; r0s = 1'b1;
    r1v = 1'b1; r1a = 32'h1234_5678; r1b = 32'h1111_1111; r1s = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_grant: got r0=%0b r1=%0b, required 1 0", req0_ready, req1_ready);
    end
    push_grants();
    out_ready = 1'b1;
    @(posedge clk); #1;
    r0v = 1'b0;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_second: got r1=%0b, required 1", req1_ready);
    end
    push_grants();
    @(posedge clk); #1;
    r1v = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_async_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain: got %0d results never produced, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
